// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared FSM state type and default operand width for the
//                bit-serial subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_sub_pkg;

  // Default operand/result width in bits
  localparam int SUB_WIDTH_DEFAULT = 8;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/sub_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : sub_bit_cell
//  Description : One-bit full subtractor: d = ai - bi - br_in, with borrow out.
//  Revision    : 1.0  initial release
// ============================================================================
module sub_bit_cell (
  input  logic ai,
  input  logic bi,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  logic w_axb;

  assign w_axb  = ai ^ bi;
  assign d      = w_axb ^ br_in;
  // Borrow when ai < bi, or when the bits are equal and a borrow is pending
  assign br_out = (~ai & bi) | (br_in & ~w_axb);

endmodule : sub_bit_cell
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial subtractor computing a - b - borrow_in one bit
//                per enabled clock, LSB first, with unsigned borrow and
//                signed overflow flags and a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               br_q,    br_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   diff_q,  diff_d;
  logic               bo_q,    bo_d;
  logic               ov_q,    ov_d;

  logic               w_bit_d;
  logic               w_bit_br;

  // Single shared cell; the counter selects which operand bits feed it
  sub_bit_cell u_bit_cell (
    .ai     (a_q[cnt_q]),
    .bi     (b_q[cnt_q]),
    .br_in  (br_q),
    .d      (w_bit_d),
    .br_out (w_bit_br)
  );

  // Next-state logic: operand capture, per-bit progress and result flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    case (state_q)
      ST_IDLE: begin
        // Acceptance does not depend on en
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (en) begin
          diff_d[cnt_q] = w_bit_d;
          br_d          = w_bit_br;
          cnt_d         = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            cnt_d   = '0;
            state_d = ST_DONE;
            bo_d    = w_bit_br;
            // Signed overflow: operands of opposite sign and result sign
            // differs from the minuend's sign
            ov_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (w_bit_d != a_q[WIDTH-1]);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign overflow   = ov_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done       = (state_q == ST_DONE);

endmodule : serial_subtractor
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 en  input  1  computation enable; low SHALL freeze all RUN-state progress.
REQ-005 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-006 a  input  WIDTH  minuend, latched on accepted start.
REQ-007 b  input  WIDTH  subtrahend, latched on accepted start.
REQ-008 borrow_in  input  1  initial borrow, latched on accepted start.
REQ-009 diff  output  WIDTH  registered result a - b - borrow_in (mod 2^WIDTH).
REQ-010 borrow_out  output  1  registered final borrow (1 when a < b + borrow_in, unsigned).
REQ-011 overflow  output  1  registered signed (two's-complement) overflow flag.
REQ-012 busy  output  1  high in RUN and DONE states.
REQ-013 done  output  1  one-cycle pulse; diff/borrow_out/overflow valid in that cycle.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch a, b, borrow_in, clear the bit counter and the diff register, and enter RUN; en is not required for acceptance.
REQ-016 RUN, en=1: each edge SHALL compute bit i (i = counter, LSB first) via d = ai ^ bi ^ br, br' = (~ai & bi) | (br & ~(ai ^ bi)); write d to diff[i]; store br'; increment the counter.
REQ-017 RUN, en=0: counter, borrow register, diff and state SHALL hold.
REQ-018 The edge that processes bit WIDTH-1 SHALL move to DONE, load borrow_out with the final borrow, and load overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
REQ-019 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally, independent of en.
REQ-020 Latency: done SHALL assert after exactly WIDTH enabled RUN edges following the accepting edge (WIDTH+1 cycles at en=1 throughout).
REQ-021 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 diff, borrow_out and overflow SHALL hold their values from DONE until the next accepted start; the diff register is cleared only on acceptance.
REQ-023 Intermediate diff bits SHALL be visible during RUN; consumers use them only when done=1.
REQ-024 Input changes on a, b, borrow_in after acceptance SHALL NOT affect the result.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, with counter=0, borrow register=0, diff=0, borrow_out=0, overflow=0, busy=0, done=0.
REQ-026 Reset SHALL take priority over start and en, and SHALL abort an in-progress operation with no done pulse.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-028 Per-bit logic SHALL be one combinational sub-module, sub_bit_cell (inputs ai, bi, br_in; outputs d, br_out), instantiated once.
REQ-029 The counter SHALL be $clog2(WIDTH) bits wide. No combinational path SHALL exist from any input to any output.

Verification (WIDTH=8)
REQ-030 a=0x35, b=0x12, borrow_in=0, en=1: pulse start -> done 9 cycles later, diff=0x23, borrow_out=0, overflow=0.
REQ-031 a=0x12, b=0x35, borrow_in=0 -> diff=0xDD, borrow_out=1, overflow=0; a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, overflow=0.
REQ-032 a=0x80, b=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, overflow=1.
REQ-033 Test en stall: a=0x35, b=0x12; drop en for 3 cycles mid-RUN -> done arrives 3 cycles later than in REQ-030, diff=0x23, and the outputs are frozen during the stall.
REQ-034 Test reset and start interactions:
- Start during RUN with new operands -> ignored; the original result is produced.
- rst_n=0 for one cycle at bit 4 -> no done pulse; all outputs are 0 the next cycle.
- A fresh start then yields a correct result.
